// File: rtl/seg7_multi_digit_driver.sv
// Multi-digit seven-segment driver.
// Captures an unsigned value and renders it on DIGITS active-low displays,
// in hexadecimal (direct nibbles) or decimal (sequential shift-and-add-3,
// one bit per clock), with optional leading-zero blanking and an overflow
// indication that replaces every digit with a dash.
//
// Ports:
//   clk       rising-edge system clock
//   reset     asynchronous active-high reset (seg blank, handshake idle)
//   value     unsigned number to display (WIDTH bits)
//   load      capture request, honoured only while busy=0
//   hex_mode  1 = hexadecimal, 0 = decimal (sampled at capture)
//   blank_lz  1 = blank leading zeros (sampled at capture)
//   busy      conversion in progress
//   done      one-cycle pulse in the first cycle the new seg is visible
//   overflow  last captured value does not fit in DIGITS digits
//   seg       digit k at [7k+6:7k], bit order g..a, active-low
module seg7_multi_digit_driver #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  input  logic                hex_mode,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [7*DIGITS-1:0] seg
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [63:0] DEC_MAX = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [63:0] HEX_LIM = 64'd1 << BW;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sr_q, sr_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hex_q, hex_d;
  logic                blz_q, blz_d;
  logic                ovf_cap_q, ovf_cap_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic [63:0]         value_ext;
  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       hex_digits;
  logic [BW-1:0]       digits;
  logic [7*DIGITS-1:0] seg_new;
  logic                leading;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0:    seg_code = 7'b1000000;
      4'h1:    seg_code = 7'b1111001;
      4'h2:    seg_code = 7'b0100100;
      4'h3:    seg_code = 7'b0110000;
      4'h4:    seg_code = 7'b0011001;
      4'h5:    seg_code = 7'b0010010;
      4'h6:    seg_code = 7'b0000010;
      4'h7:    seg_code = 7'b1111000;
      4'h8:    seg_code = 7'b0000000;
      4'h9:    seg_code = 7'b0010000;
      4'hA:    seg_code = 7'b0001000;
      4'hB:    seg_code = 7'b0000011;
      4'hC:    seg_code = 7'b1000110;
      4'hD:    seg_code = 7'b0100001;
      4'hE:    seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  // In hex mode the shift register is never shifted, so it still holds the
  // captured value; nibbles beyond WIDTH read as zero.
  if (WIDTH >= BW) begin : g_hex_trunc
    assign hex_digits = sr_q[BW-1:0];
  end else begin : g_hex_pad
    assign hex_digits = {{(BW - WIDTH){1'b0}}, sr_q};
  end

  always_comb begin
    value_ext = 64'(value);

    for (int unsigned k = 0; k < DIGITS; k++) begin
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                     : bcd_q[4*k +: 4];
    end

    digits = hex_q ? hex_digits : bcd_q;

    // Walk from the most significant digit down; blanking stops at the
    // first nonzero digit and never reaches digit 0.
    seg_new = '1;
    leading = blz_q;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (ovf_cap_q) begin
        seg_new[7*(DIGITS-1-j) +: 7] = 7'b0111111;
      end else if (leading && (j != DIGITS - 1) &&
                   (digits[4*(DIGITS-1-j) +: 4] == 4'd0)) begin
        seg_new[7*(DIGITS-1-j) +: 7] = 7'b1111111;
      end else begin
        leading = 1'b0;
        seg_new[7*(DIGITS-1-j) +: 7] = seg_code(digits[4*(DIGITS-1-j) +: 4]);
      end
    end

    state_d   = state_q;
    sr_d      = sr_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    blz_d     = blz_q;
    ovf_cap_d = ovf_cap_q;
    seg_d     = seg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d      = value;
          bcd_d     = '0;
          cnt_d     = '0;
          hex_d     = hex_mode;
          blz_d     = blank_lz;
          ovf_cap_d = hex_mode ? (value_ext >= HEX_LIM) : (value_ext > DEC_MAX);
          state_d   = hex_mode ? UPDATE : SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        seg_d   = seg_new;
        ovf_d   = ovf_cap_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      hex_q     <= 1'b0;
      blz_q     <= 1'b0;
      ovf_cap_q <= 1'b0;
      seg_q     <= '1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      blz_q     <= blz_d;
      ovf_cap_q <= ovf_cap_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg7_multi_digit_driver.sv
module tb_seg7_multi_digit_driver;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int D2 = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           load = 1'b0;
  logic           hex_mode = 1'b0;
  logic           blank_lz = 1'b0;
  logic [W-1:0]   value = '0;
  logic           busy, done, overflow;
  logic [7*D-1:0] seg;
  logic           busy2, done2, overflow2;
  logic [7*D2-1:0] seg2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seg7_multi_digit_driver #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy), .done(done),
    .overflow(overflow), .seg(seg)
  );

  seg7_multi_digit_driver #(.WIDTH(W), .DIGITS(D2)) dut2 (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy2), .done(done2),
    .overflow(overflow2), .seg(seg2)
  );

  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic bit model_ovf(int unsigned v, bit hex, int unsigned nd);
    longint unsigned lim = 1;
    for (int i = 0; i < int'(nd); i++) lim = lim * (hex ? 16 : 10);
    return longint'(v) >= lim;
  endfunction

  function automatic logic [55:0] render(int unsigned v, bit hex, bit blz, int unsigned nd);
    logic [55:0] r = '1;
    int unsigned base = hex ? 16 : 10;
    int unsigned dg [8];
    int unsigned t = v;
    int msd = 0;
    for (int k = 0; k < int'(nd); k++) begin
      dg[k] = t % base;
      t = t / base;
      if (dg[k] != 0) msd = k;
    end
    for (int k = 0; k < int'(nd); k++) begin
      if (model_ovf(v, hex, nd))  r[7*k +: 7] = 7'b0111111;
      else if (blz && k > msd)    r[7*k +: 7] = 7'b1111111;
      else                        r[7*k +: 7] = seg_tab[dg[k]];
    end
    return r;
  endfunction

  // Transaction-level model of the D-digit instance.
  int             m_rem = 0;
  int unsigned    m_val = 0;
  bit             m_hex = 0, m_blz = 0;
  logic [7*D-1:0] exp_seg = '1;
  bit             exp_ovf = 0, exp_done = 0;
  logic [55:0]    m_tmp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem = 0; exp_seg = '1; exp_ovf = 0; exp_done = 0;
    end else begin
      exp_done = 0;
      if (m_rem == 1) begin
        m_tmp    = render(m_val, m_hex, m_blz, D);
        exp_seg  = m_tmp[7*D-1:0];
        exp_ovf  = model_ovf(m_val, m_hex, D);
        exp_done = 1;
        m_rem    = 0;
      end else if (m_rem > 1) begin
        m_rem--;
      end else if (load) begin
        m_val = value; m_hex = hex_mode; m_blz = blank_lz;
        m_rem = hex_mode ? 1 : W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (m_rem != 0)) begin
        errors++; $display("FAIL cyc_busy t=%0t act=%b exp=%b", $time, busy, (m_rem != 0));
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL cyc_done t=%0t act=%b exp=%b", $time, done, exp_done);
      end
      checks++;
      if (overflow !== exp_ovf) begin
        errors++; $display("FAIL cyc_ovf t=%0t act=%b exp=%b", $time, overflow, exp_ovf);
      end
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL cyc_seg t=%0t act=%b exp=%b", $time, seg, exp_seg);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic h, input logic b);
    @(negedge clk);
    value = v; hex_mode = h; blank_lz = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pulses;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_seg", 64'(seg), 64'(21'h1FFFFF));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;

    do_load(8'd123, 1'b0, 1'b0);
    wait_done("dec123", 9);
    chk("dec123_seg", 64'(seg), 64'(21'b1111001_0100100_0110000));
    chk("dec123_ovf", 64'(overflow), 64'd0);

    do_load(8'd7, 1'b0, 1'b1);
    wait_done("dec7", 9);
    chk("dec7_blz_seg", 64'(seg), 64'(21'b1111111_1111111_1111000));

    do_load(8'd0, 1'b0, 1'b1);
    wait_done("dec0", 9);
    chk("dec0_blz_seg", 64'(seg), 64'(21'b1111111_1111111_1000000));

    do_load(8'hAB, 1'b1, 1'b0);
    wait_done("hexab", 1);
    chk("hexab_seg", 64'(seg), 64'(21'b1000000_0001000_0000011));

    do_load(8'hAB, 1'b1, 1'b1);
    wait_done("hexab_blz", 1);
    chk("hexab_blz_seg", 64'(seg), 64'(21'b1111111_0001000_0000011));

    do_load(8'd200, 1'b0, 1'b0);
    wait_done("dec200", 9);
    chk("dec200_seg", 64'(seg), 64'(21'b0100100_1000000_1000000));
    chk("d2_200_done", 64'(done2), 64'd1);
    chk("d2_200_ovf", 64'(overflow2), 64'd1);
    chk("d2_200_seg", 64'(seg2), 64'(14'b0111111_0111111));

    do_load(8'd99, 1'b0, 1'b0);
    wait_done("dec99", 9);
    chk("d2_99_ovf", 64'(overflow2), 64'd0);
    chk("d2_99_seg", 64'(seg2), 64'(14'b0010000_0010000));

    // second load arrives while busy and must be dropped
    @(negedge clk);
    value = 8'd42; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    value = 8'd5;
    @(negedge clk);
    load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("busy_ignore_pulses", 64'(pulses), 64'd1);
    chk("busy_ignore_seg", 64'(seg), 64'(21'b1000000_0011001_0100100));

    // reset in the middle of a decimal conversion
    do_load(8'd77, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_seg", 64'(seg), 64'(21'h1FFFFF));
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);

    do_load(8'd255, 1'b0, 1'b0);
    wait_done("dec255", 9);
    chk("dec255_seg", 64'(seg), 64'(21'b0100100_0010010_0010010));

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
